// File: rtl/brent_kung.sv
// brent_kung: registered Brent-Kung parallel-prefix adder.
//
// Adds two (ADDER_SIZE-1)-bit unsigned operands A and B plus cin and
// registers the (ADDER_SIZE-1)-bit sum and the carry out of the top bit.
// Prefix position 0 carries cin (as a pure generate), positions
// 1..ADDER_SIZE-1 carry the operand bits, so the tree spans ADDER_SIZE
// positions.
//
// Optional feature, controlled by the macro BRENT_KUNG_INPUT_REG_EN:
//   defined   - A, B and cin are registered ahead of the tree (2-cycle latency)
//   undefined - the tree is fed straight from the ports (1-cycle latency)
//
// Reset is synchronous and active-low; every register clears to zero.

module brent_kung #(
    parameter int ADDER_SIZE = 16,
    parameter int GROUP_SIZE = 4,
    parameter int lev        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDER_SIZE-1:1] A,
    input  logic [ADDER_SIZE-1:1] B,
    input  logic                  cin,
    output logic [ADDER_SIZE-1:1] sum,
    output logic                  cout
);

    // ------------------------------------------------------------------
    // Derived tree geometry
    // ------------------------------------------------------------------
    // LOG_G upsweep levels close each GROUP_SIZE group; the remaining
    // LOG_N-LOG_G levels combine group results across groups.  Together
    // with the intra-group closing stage that makes lev group-level stages.
    localparam int LOG_N      = $clog2(ADDER_SIZE);
    localparam int LOG_G      = $clog2(GROUP_SIZE);
    localparam int NUM_GROUPS = ADDER_SIZE / GROUP_SIZE;

    // ------------------------------------------------------------------
    // Parameter legality: refuse to elaborate a tree that cannot be built
    // ------------------------------------------------------------------
    generate
        if (GROUP_SIZE < 2 || (GROUP_SIZE & (GROUP_SIZE - 1)) != 0) begin : g_bad_group
            $error("brent_kung: GROUP_SIZE=%0d must be a power of two >= 2", GROUP_SIZE);
        end
        if (ADDER_SIZE < GROUP_SIZE || (ADDER_SIZE % GROUP_SIZE) != 0 ||
            (NUM_GROUPS & (NUM_GROUPS - 1)) != 0) begin : g_bad_size
            $error("brent_kung: ADDER_SIZE=%0d must be a power-of-two multiple of GROUP_SIZE=%0d",
                   ADDER_SIZE, GROUP_SIZE);
        end
        if (lev != $clog2(NUM_GROUPS) + 1) begin : g_bad_lev
            $error("brent_kung: lev=%0d inconsistent, expected %0d",
                   lev, $clog2(NUM_GROUPS) + 1);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Prefix-tree primitives
    // ------------------------------------------------------------------
    // Group generate/propagate pair carried through the tree.
    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    // Carry combine operator: (G,P) o (G',P') = (G | P&G', P&P').
    // 'hi' is the more significant span, 'lo' the adjacent lower span.
    function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
        gp_t res;
        res.g = hi.g | (hi.p & lo.g);
        res.p = hi.p & lo.p;
        return res;
    endfunction

    // Brent-Kung prefix over all ADDER_SIZE positions.  Returns c[i], the
    // carry out of position i, i.e. the group generate of span [i:0].
    // Nodes are updated in place: at every level the source node of a
    // combine is never itself a target at that level, so ordering within a
    // level does not matter.
    function automatic logic [ADDER_SIZE-1:0] bk_carries(
        input logic [ADDER_SIZE-1:0] g_bit,
        input logic [ADDER_SIZE-1:0] p_bit
    );
        gp_t                   node [ADDER_SIZE];
        logic [ADDER_SIZE-1:0] carry;

        for (int i = 0; i < ADDER_SIZE; i++) begin
            node[i].g = g_bit[i];
            node[i].p = p_bit[i];
        end

        // Upsweep inside each GROUP_SIZE group: after these levels the top
        // node of every group holds the whole group's (G,P).
        for (int l = 1; l <= LOG_G; l++) begin
            for (int i = (1 << l) - 1; i < ADDER_SIZE; i += (1 << l)) begin
                node[i] = gp_combine(node[i], node[i - (1 << (l - 1))]);
            end
        end

        // Upsweep across groups: pair group results into ever wider spans
        // until the top node holds the span [ADDER_SIZE-1:0].
        for (int l = LOG_G + 1; l <= LOG_N; l++) begin
            for (int i = (1 << l) - 1; i < ADDER_SIZE; i += (1 << l)) begin
                node[i] = gp_combine(node[i], node[i - (1 << (l - 1))]);
            end
        end

        // Downsweep: every node midway between two completed prefixes picks
        // up the completed prefix just below its own span.
        for (int l = LOG_N - 1; l >= 1; l--) begin
            for (int i = (3 << (l - 1)) - 1; i < ADDER_SIZE; i += (1 << l)) begin
                node[i] = gp_combine(node[i], node[i - (1 << (l - 1))]);
            end
        end

        for (int i = 0; i < ADDER_SIZE; i++) begin
            carry[i] = node[i].g;
        end
        return carry;
    endfunction

    // ------------------------------------------------------------------
    // Operand source: optional input register stage
    // ------------------------------------------------------------------
    logic [ADDER_SIZE-1:1] a_core;
    logic [ADDER_SIZE-1:1] b_core;
    logic                  cin_core;

`ifdef BRENT_KUNG_INPUT_REG_EN
    logic [ADDER_SIZE-1:1] a_q;
    logic [ADDER_SIZE-1:1] b_q;
    logic                  cin_q;

    // Capture operands one cycle ahead of the tree; cleared by reset so an
    // in-flight operand is discarded along with the output.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
        end else begin
            a_q   <= A;
            b_q   <= B;
            cin_q <= cin;
        end
    end

    assign a_core   = a_q;
    assign b_core   = b_q;
    assign cin_core = cin_q;
`else
    assign a_core   = A;
    assign b_core   = B;
    assign cin_core = cin;
`endif

    // ------------------------------------------------------------------
    // Combinational adder core
    // ------------------------------------------------------------------
    logic [ADDER_SIZE-1:0] g_bit;
    logic [ADDER_SIZE-1:0] p_bit;
    logic [ADDER_SIZE-1:0] carry;
    logic [ADDER_SIZE-1:1] sum_next;
    logic                  cout_next;

    // Bit-level generate/propagate, prefix carries and sum bits.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        g_bit     = '0;
        p_bit     = '0;
        carry     = '0;
        sum_next  = '0;
        cout_next = 1'b0;

        // Position 0 is the carry-in: a generate with no propagate.
        g_bit[0]              = cin_core;
        p_bit[0]              = 1'b0;
        g_bit[ADDER_SIZE-1:1] = a_core & b_core;
        p_bit[ADDER_SIZE-1:1] = a_core ^ b_core;

        carry = bk_carries(g_bit, p_bit);

        // sum[i] = p[i] ^ c[i-1]; c[0] is the carry out of the cin slot.
        sum_next  = p_bit[ADDER_SIZE-1:1] ^ carry[ADDER_SIZE-2:0];
        cout_next = carry[ADDER_SIZE-1];
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    // Register the result; reset wins over any input at the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= sum_next;
            cout <= cout_next;
        end
    end

endmodule

// File: tb/tb_brent_kung.sv
// tb_brent_kung: self-checking bench for brent_kung (default parameters).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// The reference is plain integer addition of the operands and carry-in.

module tb_brent_kung;

    localparam int W = 15;
`ifdef BRENT_KUNG_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    brent_kung #(
        .ADDER_SIZE(16),
        .GROUP_SIZE(4),
        .lev       (3)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .A    (A),
        .B    (B),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    // Reference: true (W+1)-bit sum {cout, sum} of A + B + cin.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
        int unsigned total;
        total = int'(a) + int'(b) + int'(c);
        return total[W:0];
    endfunction

    // Reset held for two edges with worst-case inputs, then first result.
    task automatic test_reset();
        logic [W:0] exp;
        rst_n = 1'b0;
        A     = 15'h7FFF;
        B     = 15'h7FFF;
        cin   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({cout, sum} !== 16'h0000) begin
                $display("FAIL reset_%0d: got cout=%0b sum=%h, want cout=0 sum=0000", i, cout, sum);
            end else begin
                pass_cnt++;
            end
        end
        rst_n = 1'b1;
        A     = 15'h1234;
        B     = 15'h0F0F;
        cin   = 1'b0;
        exp   = 16'h2143;
        repeat (LAT) @(negedge clk);
        total_cnt++;
        if ({cout, sum} !== exp) begin
            $display("FAIL first_after_reset: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     cout, sum, exp[W], exp[W-1:0]);
        end else begin
            pass_cnt++;
        end
    endtask

    // Directed vectors with hand-computed results.
    task automatic test_directed();
        logic [W-1:0] ta   [6] = '{15'h0000, 15'h01E0, 15'h01E0, 15'h78F0, 15'h7FFF, 15'h7FFF};
        logic [W-1:0] tb_v [6] = '{15'h0000, 15'h000F, 15'h000F, 15'h780F, 15'h0000, 15'h7FFF};
        logic         tc   [6] = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1};
        logic [W:0]   te   [6] = '{16'h0000, 16'h01EF, 16'h01F0, 16'hF100, 16'h8000, 16'hFFFF};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            A   = ta[k];
            B   = tb_v[k];
            cin = tc[k];
            repeat (LAT) @(negedge clk);
            total_cnt++;
            if ({cout, sum} !== te[k]) begin
                $display("FAIL directed_%0d: got cout=%0b sum=%h, want cout=%0b sum=%h",
                         k, cout, sum, te[k][W], te[k][W-1:0]);
            end else begin
                pass_cnt++;
            end
        end
    endtask

    // New random operands every cycle, each result checked LAT cycles later.
    task automatic test_back_to_back();
        logic [W:0]   exp_q [$];
        logic [W:0]   exp;
        logic [W-1:0] a_r;
        logic [W-1:0] b_r;
        logic         c_r;
        localparam int N_VEC = 300;
        for (int i = 0; i < N_VEC + LAT; i++) begin
            @(negedge clk);
            if (exp_q.size() == LAT) begin
                exp = exp_q.pop_front();
                total_cnt++;
                if ({cout, sum} !== exp) begin
                    $display("FAIL b2b_%0d: got cout=%0b sum=%h, want cout=%0b sum=%h",
                             i, cout, sum, exp[W], exp[W-1:0]);
                end else begin
                    pass_cnt++;
                end
            end
            if (i < N_VEC) begin
                a_r = W'($urandom);
                b_r = W'($urandom);
                c_r = 1'($urandom);
                // Bias some vectors toward long propagate chains.
                case ($urandom_range(0, 5))
                    0: b_r = ~a_r;
                    1: a_r = '1;
                    2: b_r = '0;
                    default: ;
                endcase
                A   = a_r;
                B   = b_r;
                cin = c_r;
                exp_q.push_back(ref_add(a_r, b_r, c_r));
            end
        end
    endtask

    // Reset arriving with an operand discards it; the next operand survives.
    task automatic test_midstream_reset();
        logic [W:0] exp;
        @(negedge clk);
        A     = 15'h5555;
        B     = 15'h2AAB;
        cin   = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            total_cnt++;
            if ({cout, sum} !== 16'h0000) begin
                $display("FAIL midreset_flush_%0d: got cout=%0b sum=%h, want cout=0 sum=0000",
                         i, cout, sum);
            end else begin
                pass_cnt++;
            end
            if (i == 0) begin
                rst_n = 1'b1;
                A     = 15'h4321;
                B     = 15'h6789;
                cin   = 1'b0;
            end
        end
        exp = 16'hAAAA;
        @(negedge clk);
        total_cnt++;
        if ({cout, sum} !== exp) begin
            $display("FAIL midreset_resume: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     cout, sum, exp[W], exp[W-1:0]);
        end else begin
            pass_cnt++;
        end
    endtask

    // Outputs hold between edges even when inputs change mid-cycle.
    task automatic test_hold();
        logic [W:0] exp;
        @(negedge clk);
        A   = 15'h0F0F;
        B   = 15'h70F1;
        cin = 1'b0;
        exp = ref_add(15'h0F0F, 15'h70F1, 1'b0);
        repeat (LAT) @(posedge clk);
        #1;
        A   = 15'h0001;
        B   = 15'h0002;
        cin = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({cout, sum} !== exp) begin
            $display("FAIL hold_mid: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     cout, sum, exp[W], exp[W-1:0]);
        end else begin
            pass_cnt++;
        end
        #3;
        total_cnt++;
        if ({cout, sum} !== exp) begin
            $display("FAIL hold_late: got cout=%0b sum=%h, want cout=%0b sum=%h",
                     cout, sum, exp[W], exp[W-1:0]);
        end else begin
            pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_midstream_reset();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
